// File: rtl/gun_tracker.sv
// Light-gun crosshair tracker: per-channel cursor positions driven by a digital
// pad (accelerating relative motion) or an analog stick (absolute), updated once per frame.
module gun_tracker #(
    parameter int CHANNELS  = 2,
    parameter int POS_W     = 8,
    parameter int H_MIN     = 0,
    parameter int H_MAX     = 255,
    parameter int V_MIN     = 0,
    parameter int V_MAX     = 239,
    parameter int SPEED_MAX = 6,
    parameter int ASHIFT    = 0
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      vblank,
    input  logic [4*CHANNELS-1:0]     joy_dir,
    input  logic [8*CHANNELS-1:0]     analog_x,
    input  logic [8*CHANNELS-1:0]     analog_y,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       recenter,
    output logic [POS_W*CHANNELS-1:0] gun_h,
    output logic [POS_W*CHANNELS-1:0] gun_v,
    output logic                      update
);

    localparam int CENTER_H = (H_MIN + H_MAX) / 2;
    localparam int CENTER_V = (V_MIN + V_MAX) / 2;
    localparam int AW       = POS_W + 2;

    typedef logic signed [AW-1:0] pos_t;
    typedef logic [3:0]           spd_t;

    localparam logic [POS_W-1:0] CEN_H = POS_W'(CENTER_H);
    localparam logic [POS_W-1:0] CEN_V = POS_W'(CENTER_V);
    localparam spd_t             SPD1  = 4'd1;
    localparam spd_t             SPDM  = spd_t'(SPEED_MAX);

    function automatic logic [POS_W-1:0] clamp_pos(input pos_t p, input int lo, input int hi);
        if (p < pos_t'(lo)) return POS_W'(lo);
        if (p > pos_t'(hi)) return POS_W'(hi);
        return POS_W'(p);
    endfunction

    // Opposing directions on one axis cancel; the speed still ramps.
    function automatic pos_t step(input logic inc, input logic dec, input spd_t s);
        if (inc && !dec) return pos_t'(s);
        if (dec && !inc) return -pos_t'(s);
        return '0;
    endfunction

    function automatic pos_t analog_pos(input logic signed [7:0] a, input int center);
        pos_t off;
        off = pos_t'(a) >>> ASHIFT;
        return pos_t'(center) + off;
    endfunction

    logic                      vb_q;
    logic                      upd_q, upd_d;
    logic [POS_W*CHANNELS-1:0] h_q, h_d;
    logic [POS_W*CHANNELS-1:0] v_q, v_d;
    logic [4*CHANNELS-1:0]     spd_q, spd_d;
    logic                      tick;
    logic [3:0]                dir;
    spd_t                      spd;
    pos_t                      hq, vq;

    always_comb begin
        tick  = vblank & ~vb_q;
        h_d   = h_q;
        v_d   = v_q;
        spd_d = spd_q;
        upd_d = tick;
        dir   = '0;
        spd   = SPD1;
        hq    = '0;
        vq    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            dir = joy_dir[4*n +: 4];
            spd = spd_q[4*n +: 4];
            hq  = pos_t'(h_q[POS_W*n +: POS_W]);
            vq  = pos_t'(v_q[POS_W*n +: POS_W]);
            if (tick) begin
                if (recenter[n]) begin
                    h_d[POS_W*n +: POS_W] = CEN_H;
                    v_d[POS_W*n +: POS_W] = CEN_V;
                    spd_d[4*n +: 4]       = SPD1;
                end else if (mode[n]) begin
                    h_d[POS_W*n +: POS_W] = clamp_pos(analog_pos(analog_x[8*n +: 8], CENTER_H), H_MIN, H_MAX);
                    v_d[POS_W*n +: POS_W] = clamp_pos(analog_pos(analog_y[8*n +: 8], CENTER_V), V_MIN, V_MAX);
                    spd_d[4*n +: 4]       = SPD1;
                end else begin
                    // bit0 right, bit1 left, bit2 down, bit3 up
                    h_d[POS_W*n +: POS_W] = clamp_pos(hq + step(dir[0], dir[1], spd), H_MIN, H_MAX);
                    v_d[POS_W*n +: POS_W] = clamp_pos(vq + step(dir[2], dir[3], spd), V_MIN, V_MAX);
                    if (dir == 4'd0)
                        spd_d[4*n +: 4] = SPD1;
                    else if (spd >= SPDM)
                        spd_d[4*n +: 4] = SPDM;
                    else
                        spd_d[4*n +: 4] = spd + 4'd1;
                end
            end
        end
    end

    // vb_q resets high so a vblank already asserted at release is not a tick.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vb_q  <= 1'b1;
            upd_q <= 1'b0;
            h_q   <= {CHANNELS{CEN_H}};
            v_q   <= {CHANNELS{CEN_V}};
            spd_q <= {CHANNELS{SPD1}};
        end else begin
            vb_q  <= vblank;
            upd_q <= upd_d;
            h_q   <= h_d;
            v_q   <= v_d;
            spd_q <= spd_d;
        end
    end

    assign gun_h  = h_q;
    assign gun_v  = v_q;
    assign update = upd_q;

endmodule

// File: tb/tb_gun_tracker.sv
// Directed bench for gun_tracker (defaults, two channels); expected coordinates
// are queued per frame and checked by a monitor whenever update pulses.
module tb_gun_tracker;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank  = 1'b1;
    logic [7:0]  joy_dir = '0;
    logic [15:0] analog_x = '0;
    logic [15:0] analog_y = '0;
    logic [1:0]  mode = '0;
    logic [1:0]  recenter = '0;
    logic [15:0] gun_h, gun_v;
    logic        update;

    gun_tracker dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .vblank   (vblank),
        .joy_dir  (joy_dir),
        .analog_x (analog_x),
        .analog_y (analog_y),
        .mode     (mode),
        .recenter (recenter),
        .gun_h    (gun_h),
        .gun_v    (gun_v),
        .update   (update)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   frame_no = 0;

    always @(negedge clk_sys) begin
        if (reset_n && update) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_update: update=1 with gun_h=%h gun_v=%h, none expected", gun_h, gun_v);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (gun_h !== e.h || gun_v !== e.v) begin
                    n_fail++;
                    $display("FAIL frame_pos: got h=%h v=%h, want h=%h v=%h", gun_h, gun_v, e.h, e.v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One frame: drive inputs, raise vblank for one cycle, drop it again.
    task automatic frame(input logic [7:0] j, input logic [15:0] ax, input logic [15:0] ay,
                         input logic [1:0] md, input logic [1:0] rc,
                         input logic [15:0] eh, input logic [15:0] ev);
        exp_t e;
        e.h = eh;
        e.v = ev;
        sb.push_back(e);
        frame_no++;
        joy_dir  = j;
        analog_x = ax;
        analog_y = ay;
        mode     = md;
        recenter = rc;
        vblank   = 1'b1;
        @(negedge clk_sys);
        vblank   = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with vblank high
        repeat (3) @(negedge clk_sys);
        check("reset_gun_h", gun_h, {8'd127, 8'd127});
        check("reset_gun_v", gun_v, {8'd119, 8'd119});
        check("reset_update", {15'd0, update}, 16'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("no_tick_after_release", {15'd0, update}, 16'd0);
        check("hold_gun_h", gun_h, {8'd127, 8'd127});
        vblank = 1'b0;
        @(negedge clk_sys);

        // Channel 0 accelerating right, channel 1 idle
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd128}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd130}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd133}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd137}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd142}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd148}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd154}, {8'd119, 8'd119});
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd160}, {8'd119, 8'd119});

        // Channel 1 placed at h=3 via analog (-124), then left into the edge
        frame(8'h00, 16'h8400, 16'h0000, 2'b10, 2'b00, {8'd3, 8'd160}, {8'd119, 8'd119});
        frame(8'h20, 16'h0, 16'h0, 2'b00, 2'b00, {8'd2, 8'd160}, {8'd119, 8'd119});
        frame(8'h20, 16'h0, 16'h0, 2'b00, 2'b00, {8'd0, 8'd160}, {8'd119, 8'd119});
        frame(8'h20, 16'h0, 16'h0, 2'b00, 2'b00, {8'd0, 8'd160}, {8'd119, 8'd119});

        // Channel 0 analog extremes clamp; channel 1 down at speed 4
        frame(8'h40, 16'h0080, 16'h007F, 2'b01, 2'b00, {8'd0, 8'd0}, {8'd123, 8'd239});
        // Channel 0 analog to (200,50)
        frame(8'h00, 16'h0049, 16'h00BB, 2'b01, 2'b00, {8'd0, 8'd200}, {8'd123, 8'd50});
        // Recenter overrides up+down+right; channel 1 moves right independently
        frame(8'h1D, 16'h0, 16'h0, 2'b00, 2'b01, {8'd1, 8'd127}, {8'd123, 8'd119});
        // Speed restarted at 1 after recenter
        frame(8'h11, 16'h0, 16'h0, 2'b00, 2'b00, {8'd3, 8'd128}, {8'd123, 8'd119});
        // Up+down cancel vertically while right still moves
        frame(8'h0D, 16'h0, 16'h0, 2'b00, 2'b00, {8'd3, 8'd130}, {8'd123, 8'd119});

        // Reset asserted just before a pending tick, released with vblank high
        joy_dir = 8'h00;
        vblank  = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk_sys);
        check("midreset_gun_h", gun_h, {8'd127, 8'd127});
        check("midreset_gun_v", gun_v, {8'd119, 8'd119});
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("midreset_no_update", {15'd0, update}, 16'd0);
        vblank = 1'b0;
        @(negedge clk_sys);
        frame(8'h01, 16'h0, 16'h0, 2'b00, 2'b00, {8'd127, 8'd128}, {8'd119, 8'd119});

        repeat (4) @(negedge clk_sys);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_updates: %0d frames produced no update, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gun_tracker.md
GUN_TRACKER -- requirements
Module: gun_tracker

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 2, number of independent player/gun channels (1..4).
REQ-002 The module SHALL have parameter POS_W, default 8, width of each gun coordinate.
REQ-003 The module SHALL have parameters H_MIN, default 0, and H_MAX, default 255, inclusive horizontal bounds.
REQ-004 The module SHALL have parameters V_MIN, default 0, and V_MAX, default 239, inclusive vertical bounds.
REQ-005 The module SHALL have parameter SPEED_MAX, default 6, maximum digital step per update (1..15).
REQ-006 The module SHALL have parameter ASHIFT, default 0, arithmetic right shift applied to analog input.
REQ-007 The module SHALL have port clk_sys  input  1  system clock; all state on its rising edge.
REQ-008 The module SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-009 The module SHALL have port vblank  input  1  video vertical blank, synchronous to clk_sys.
REQ-010 The module SHALL have port joy_dir  input  4*CHANNELS  per channel {up,down,left,right}, bit0 = right, bit3 = up, channel n at [4n+3:4n].
REQ-011 The module SHALL have port analog_x, analog_y  input  8*CHANNELS each  signed two's-complement stick position per channel.
REQ-012 The module SHALL have port mode  input  CHANNELS  per channel: 0 = digital relative, 1 = analog absolute.
REQ-013 The module SHALL have port recenter  input  CHANNELS  per channel request to return to centre.
REQ-014 The module SHALL have port gun_h, gun_v  output  POS_W*CHANNELS each  registered coordinates, channel n at [POS_W*n+POS_W-1:POS_W*n].
REQ-015 The module SHALL have port update  output  1  one-cycle pulse marking new coordinates.

Function
REQ-016 CENTER_H SHALL be (H_MIN+H_MAX)/2 and CENTER_V SHALL be (V_MIN+V_MAX)/2, integer-truncated.
REQ-017 A registered copy vb_q SHALL be kept; tick = vblank AND NOT vb_q.
REQ-018 All channel updates SHALL occur on the clk_sys edge where tick = 1, with new gun_h/gun_v and update = 1 visible in the following cycle; latency from first vblank-high cycle to new outputs is 1 clock.
REQ-019 Between ticks, gun_h, gun_v and speed registers SHALL hold; update SHALL be 0.
REQ-020 Per channel, a speed register (1..SPEED_MAX) SHALL exist; on a tick in digital mode with any direction held, speed SHALL increment by 1 saturating at SPEED_MAX after being applied; with no direction held, speed SHALL reset to 1.
REQ-021 Digital mode: right adds speed to h, left subtracts; down adds speed to v, up subtracts; both directions of one axis held SHALL give no motion on that axis (speed still ramps).
REQ-022 Position arithmetic SHALL be done signed in POS_W+2 bits and clamped to [H_MIN,H_MAX] / [V_MIN,V_MAX]; no wrap-around at any edge.
REQ-023 Analog mode: h = CENTER_H + (analog_x >>> ASHIFT), v = CENTER_V + (analog_y >>> ASHIFT), clamped per REQ-022; speed SHALL be forced to 1.
REQ-024 recenter[n] high on a tick SHALL set channel n to (CENTER_H, CENTER_V) and speed to 1, overriding REQ-020..023.
REQ-025 Mode change takes effect at the next tick; no state beyond speed is carried between modes.
REQ-026 Channels SHALL be fully independent; one channel's inputs never affect another.

Reset
REQ-027 While reset_n = 0: all gun_h = CENTER_H, all gun_v = CENTER_V, speed = 1, update = 0, vb_q = 1 (no spurious tick if vblank is high when reset releases).
REQ-028 Reset asserted mid-frame SHALL abort any pending update immediately; first tick after release requires a vblank low-to-high transition.

Verification
REQ-029 Reset release with vblank held high, defaults -> gun_h = 127, gun_v = 119, update stays 0 until vblank falls and rises again.
REQ-030 Channel 0 digital, right held 8 ticks from centre -> gun_h sequence 128,130,133,137,142,148,154,160; speed saturates at 6.
REQ-031 Channel 1 digital, left held from h = 3 -> h = 2, then 0, then stays 0 (clamped, no wrap to 255); gun_v unchanged.
REQ-032 Channel 0 analog, analog_x = -128, analog_y = +127, ASHIFT = 0 -> gun_h = 0, gun_v = 239 one cycle after tick, update = 1 that cycle.
REQ-033 Channel 0 at (200,50) with up+down+right held and recenter[0] = 1 on same tick -> (127,119), speed 1; channel 1 simultaneously moves per its own inputs.
